// File: rtl/aes128_key_expand_last.sv
// aes128_key_expand_last
// Iterative AES-128 forward key schedule. A load edge captures the cipher key.
// Each of the next ten edges computes one round key. Round key 10 is the
// starting key of the inverse cipher and is held on round_key_10 until the
// next round-10 edge.
// Optional feature macro: AES128_KEY_STREAM_EN. When it is defined, the module
// also exposes every intermediate round key, so a forward cipher core can use
// the keys as they are produced.
module aes128_key_expand_last (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic [127:0] cipher_key,
    input  logic         key_en,
    output logic [127:0] round_key_10,
    output logic         key_ready,
    output logic         key_busy
`ifdef AES128_KEY_STREAM_EN
    ,
    output logic [127:0] round_key,
    output logic [3:0]   round_key_idx,
    output logic         round_key_valid
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Forward AES S-box lookup; one call per byte of the rotated w3 word.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return SBOX[x];
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [127:0]  r_w;
    logic [127:0]  w_w_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [7:0]    r_rcon;
    logic [7:0]    w_rcon_nxt;
    logic [127:0]  r_rk10;
    logic [127:0]  w_rk10_nxt;
    logic          r_ready;
    logic          w_ready_nxt;
    logic          r_busy;
    logic          w_busy_nxt;

    // One round of the forward key schedule, computed from the working key w.
    logic [31:0]   w_w3;
    logic [31:0]   w_rot;
    logic [31:0]   w_sub;
    logic [31:0]   w_t;
    logic [31:0]   w_k0;
    logic [31:0]   w_k1;
    logic [31:0]   w_k2;
    logic [31:0]   w_k3;
    logic [127:0]  w_round;
    logic [7:0]    w_rcon_xt;

    assign w_w3      = r_w[31:0];
    assign w_rot     = {w_w3[23:0], w_w3[31:24]};
    assign w_sub     = {sbox_fwd(w_rot[31:24]), sbox_fwd(w_rot[23:16]),
                        sbox_fwd(w_rot[15:8]),  sbox_fwd(w_rot[7:0])};
    assign w_t       = w_sub ^ {r_rcon, 24'h000000};
    assign w_k0      = r_w[127:96] ^ w_t;
    assign w_k1      = r_w[95:64]  ^ w_k0;
    assign w_k2      = r_w[63:32]  ^ w_k1;
    assign w_k3      = r_w[31:0]   ^ w_k2;
    assign w_round   = {w_k0, w_k1, w_k2, w_k3};
    // xtime in GF(2^8): 80 wraps to 1b, then 36.
    assign w_rcon_xt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

`ifdef AES128_KEY_STREAM_EN
    logic [3:0]    r_idx;
    logic [3:0]    w_idx_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
`endif

    // Next-state and next-datapath decode; every register holds by default.
    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_cnt_nxt   = r_cnt;
        w_rcon_nxt  = r_rcon;
        w_rk10_nxt  = r_rk10;
        w_ready_nxt = r_ready;
        w_busy_nxt  = r_busy;
`ifdef AES128_KEY_STREAM_EN
        w_idx_nxt   = r_idx;
        w_valid_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (key_en) begin
                    w_state_nxt = ST_BUSY;
                    w_w_nxt     = cipher_key;
                    w_cnt_nxt   = 4'd1;
                    w_rcon_nxt  = 8'h01;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
`ifdef AES128_KEY_STREAM_EN
                    w_idx_nxt   = 4'd0;
                    w_valid_nxt = 1'b1;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // key_en is not looked at here: an in-flight expansion always completes.
                w_w_nxt    = w_round;
                w_cnt_nxt  = r_cnt + 4'd1;
                w_rcon_nxt = w_rcon_xt;
`ifdef AES128_KEY_STREAM_EN
                w_idx_nxt   = r_cnt;
                w_valid_nxt = 1'b1;
`endif
                if (r_cnt == 4'd10) begin
                    w_state_nxt = ST_IDLE;
                    w_rk10_nxt  = w_round;
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            default: begin
                // Unreachable encoding: drop back to IDLE without claiming a result.
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Working key, round counter, rcon and registered outputs.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_w     <= 128'h0;
            r_cnt   <= 4'd0;
            r_rcon  <= 8'h01;
            r_rk10  <= 128'h0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_w     <= w_w_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rcon  <= w_rcon_nxt;
            r_rk10  <= w_rk10_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign round_key_10 = r_rk10;
    assign key_ready    = r_ready;
    assign key_busy     = r_busy;

`ifdef AES128_KEY_STREAM_EN
    // Round-key stream index and valid flag.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= 4'd0;
            r_valid <= 1'b0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign round_key       = r_w;
    assign round_key_idx   = r_idx;
    assign round_key_valid = r_valid;
`endif

endmodule

// File: tb/tb_aes128_key_expand_last.sv
// Self-checking bench for aes128_key_expand_last: a table of known FIPS-197
// keys and their round-10 keys, plus directed sequences for reset during an
// expansion, key_en while busy, and back-to-back restarts.
module tb_aes128_key_expand_last;

    logic         clk_sys = 1'b0;
    logic         rst_n;
    logic [127:0] cipher_key;
    logic         key_en;
    logic [127:0] round_key_10;
    logic         key_ready;
    logic         key_busy;
`ifdef AES128_KEY_STREAM_EN
    logic [127:0] round_key;
    logic [3:0]   round_key_idx;
    logic         round_key_valid;
`endif

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] EXP_A1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] EXP_C1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_Z   = 128'h0;
    localparam logic [127:0] EXP_Z   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [127:0] key;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [3];
    logic [127:0] model_rk10;

    always #5 clk_sys = ~clk_sys;

    aes128_key_expand_last dut (
        .clk_sys        (clk_sys),
        .rst_n          (rst_n),
        .cipher_key     (cipher_key),
        .key_en         (key_en),
        .round_key_10   (round_key_10),
        .key_ready      (key_ready),
        .key_busy       (key_busy)
`ifdef AES128_KEY_STREAM_EN
        ,
        .round_key      (round_key),
        .round_key_idx  (round_key_idx),
        .round_key_valid(round_key_valid)
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Load a key with a one-cycle key_en and check timing through edge N+10.
    task automatic run_key(input logic [127:0] key, input logic [127:0] exp, input string tag);
        cipher_key = key;
        key_en     = 1'b1;
        tick();                                  // edge N (load)
        key_en     = 1'b0;
        cipher_key = ~key;                       // sampled only on the load edge
        check({tag, " busy@N"},  {127'h0, key_busy},  128'h1);
        check({tag, " ready@N"}, {127'h0, key_ready}, 128'h0);
        check({tag, " rk10 held@N"}, round_key_10, model_rk10);
`ifdef AES128_KEY_STREAM_EN
        check({tag, " stream key@N"}, round_key, key);
        check({tag, " stream idx@N"}, {124'h0, round_key_idx}, 128'h0);
`endif
        for (int i = 1; i <= 9; i++) begin
            tick();                              // edges N+1 .. N+9
        end
        check({tag, " ready@N+9"}, {127'h0, key_ready}, 128'h0);
        check({tag, " busy@N+9"},  {127'h0, key_busy},  128'h1);
        check({tag, " rk10 held@N+9"}, round_key_10, model_rk10);
        tick();                                  // edge N+10
        model_rk10 = exp;
        check({tag, " rk10@N+10"}, round_key_10, model_rk10);
        check({tag, " ready@N+10"}, {127'h0, key_ready}, 128'h1);
        check({tag, " busy@N+10"},  {127'h0, key_busy},  128'h0);
`ifdef AES128_KEY_STREAM_EN
        check({tag, " stream key@N+10"}, round_key, exp);
        check({tag, " stream idx@N+10"}, {124'h0, round_key_idx}, 128'ha);
        check({tag, " stream valid@N+10"}, {127'h0, round_key_valid}, 128'h1);
`endif
    endtask

    initial begin
        vecs[0] = '{key: KEY_A1, exp: EXP_A1};
        vecs[1] = '{key: KEY_C1, exp: EXP_C1};
        vecs[2] = '{key: KEY_Z,  exp: EXP_Z};

        rst_n      = 1'b0;
        key_en     = 1'b0;
        cipher_key = 128'h0;
        model_rk10 = 128'h0;
        #12;
        check("reset rk10",  round_key_10, 128'h0);
        check("reset ready", {127'h0, key_ready}, 128'h0);
        check("reset busy",  {127'h0, key_busy},  128'h0);
        @(negedge clk_sys);
        rst_n = 1'b1;

        // Table-driven known-answer vectors.
        for (int v = 0; v < 3; v++) begin
            run_key(vecs[v].key, vecs[v].exp, $sformatf("vec%0d", v));
            tick();
            check($sformatf("vec%0d rk10 stable", v), round_key_10, model_rk10);
            check($sformatf("vec%0d idle busy", v), {127'h0, key_busy}, 128'h0);
        end

        // key_en during BUSY is ignored.
        cipher_key = KEY_C1;
        key_en     = 1'b1;
        tick();                                  // edge N
        key_en     = 1'b0;
        for (int i = 1; i <= 3; i++) tick();     // edges N+1..N+3
        cipher_key = KEY_A1;
        key_en     = 1'b1;
        tick();                                  // edge N+4
        key_en     = 1'b0;
        for (int i = 5; i <= 9; i++) tick();
        check("ignore busy@N+9", {127'h0, key_busy}, 128'h1);
        tick();                                  // edge N+10
        model_rk10 = EXP_C1;
        check("ignore rk10@N+10", round_key_10, model_rk10);
        check("ignore ready@N+10", {127'h0, key_ready}, 128'h1);
        tick();
        check("ignore no restart busy", {127'h0, key_busy}, 128'h0);
        check("ignore no restart ready", {127'h0, key_ready}, 128'h1);

        // Back-to-back: key_en held high across completion.
        cipher_key = KEY_Z;
        key_en     = 1'b1;
        tick();                                  // load from IDLE with ready=1
        check("b2b ready drops", {127'h0, key_ready}, 128'h0);
        check("b2b busy@load",   {127'h0, key_busy},  128'h1);
        check("b2b rk10 held@load", round_key_10, model_rk10);
        for (int i = 1; i <= 9; i++) tick();
        check("b2b rk10 held@N+9", round_key_10, model_rk10);
        tick();                                  // edge N+10
        model_rk10 = EXP_Z;
        check("b2b rk10@N+10", round_key_10, model_rk10);
        check("b2b ready@N+10", {127'h0, key_ready}, 128'h1);
        tick();                                  // key_en still high: restart
        key_en = 1'b0;
        check("b2b restart ready", {127'h0, key_ready}, 128'h0);
        check("b2b restart busy",  {127'h0, key_busy},  128'h1);
        for (int i = 1; i <= 10; i++) tick();
        check("b2b second rk10", round_key_10, model_rk10);
        check("b2b second ready", {127'h0, key_ready}, 128'h1);

        // Reset asserted while round 5 is being computed.
        cipher_key = KEY_C1;
        key_en     = 1'b1;
        tick();                                  // edge N
        key_en     = 1'b0;
        for (int i = 1; i <= 4; i++) tick();     // edges N+1..N+4
        rst_n = 1'b0;
        #1;
        model_rk10 = 128'h0;
        check("midrst rk10",  round_key_10, model_rk10);
        check("midrst ready", {127'h0, key_ready}, 128'h0);
        check("midrst busy",  {127'h0, key_busy},  128'h0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_n = 1'b1;
        run_key(KEY_C1, EXP_C1, "postrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
